// File: rtl/video_start_controller.sv
// Start sequencer for the output video generator: waits for a stable PLL and an
// input frame, fires a delayed start pulse, then restarts if input frames stop.
module video_start_controller #(
    parameter int START_DELAY = 16,
    parameter int LOCK_STABLE = 1024,
    parameter int TIMEOUT     = 4194304
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       config_changed,
    input  logic       input_frame_start,
    input  logic       fullcycle,
    output logic       starttrigger,
    output logic       video_reset,
    output logic       running,
    output logic [7:0] restart_count,
    output logic [2:0] state
);

    localparam int LW = (LOCK_STABLE < 2) ? 1 : $clog2(LOCK_STABLE);
    localparam int DW = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        WAIT_LOCK  = 3'd1,
        WAIT_FRAME = 3'd2,
        DELAY      = 3'd3,
        TRIGGER    = 3'd4,
        RUN        = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    holdCnt_q, holdCnt_d;
    logic [LW-1:0] lockCnt_q, lockCnt_d;
    logic [DW-1:0] delayCnt_q, delayCnt_d;
    logic [23:0]   watchdog_q, watchdog_d;
    logic [7:0]    restartCount_q, restartCount_d;
    logic          startTrigger_q;
    logic          videoReset_q;
    logic          runState_q;

    // Lost lock outranks a config change, which outranks frame and watchdog events.
    always_comb begin
        state_d        = state_q;
        restartCount_d = restartCount_q;
        case (state_q)
            HOLD: begin
                if (!config_changed && holdCnt_q == 4'hF) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (config_changed)
                    state_d = HOLD;
                else if (pll_locked && lockCnt_q == LW'(LOCK_STABLE - 1))
                    state_d = WAIT_FRAME;
            end
            WAIT_FRAME, DELAY, TRIGGER, RUN: begin
                if (!pll_locked) begin
                    state_d = WAIT_LOCK;
                end else if (config_changed) begin
                    state_d = HOLD;
                end else begin
                    case (state_q)
                        WAIT_FRAME: begin
                            if (input_frame_start)
                                state_d = (START_DELAY == 0) ? TRIGGER : DELAY;
                        end
                        DELAY: begin
                            if (delayCnt_q == DW'(START_DELAY)) state_d = TRIGGER;
                        end
                        TRIGGER: state_d = RUN;
                        default: begin
                            if (!input_frame_start && watchdog_q == 24'(TIMEOUT - 1)) begin
                                state_d = HOLD;
                                if (restartCount_q != 8'hFF)
                                    restartCount_d = restartCount_q + 8'd1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // Each counter runs only while its state persists; any entry starts it afresh.
    always_comb begin
        holdCnt_d  = (state_q == HOLD && state_d == HOLD && !config_changed)
                   ? holdCnt_q + 4'd1 : 4'd0;
        lockCnt_d  = (state_q == WAIT_LOCK && state_d == WAIT_LOCK && pll_locked)
                   ? lockCnt_q + LW'(1) : '0;
        delayCnt_d = (state_d != DELAY) ? '0
                   : (state_q == DELAY) ? delayCnt_q + DW'(1) : DW'(1);
        watchdog_d = (state_q == RUN && state_d == RUN && !input_frame_start)
                   ? watchdog_q + 24'd1 : 24'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= HOLD;
            holdCnt_q      <= 4'd0;
            lockCnt_q      <= '0;
            delayCnt_q     <= '0;
            watchdog_q     <= 24'd0;
            restartCount_q <= 8'd0;
            startTrigger_q <= 1'b0;
            videoReset_q   <= 1'b1;
            runState_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            holdCnt_q      <= holdCnt_d;
            lockCnt_q      <= lockCnt_d;
            delayCnt_q     <= delayCnt_d;
            watchdog_q     <= watchdog_d;
            restartCount_q <= restartCount_d;
            startTrigger_q <= (state_d == TRIGGER);
            videoReset_q   <= (state_d == HOLD) || (state_d == WAIT_LOCK) || (state_d == WAIT_FRAME);
            runState_q     <= (state_d == RUN);
        end
    end

    assign starttrigger  = startTrigger_q;
    assign video_reset   = videoReset_q;
    assign running       = runState_q & fullcycle;
    assign restart_count = restartCount_q;
    assign state         = state_q;

endmodule

// File: tb/tb_video_start_controller.sv
// Bench for video_start_controller: two instances (long delay/lock, zero delay/short lock)
// checked every cycle against a timestamp-based model of the start sequence.
module tb_video_start_controller;

    localparam int ST_HOLD = 0, ST_LOCK = 1, ST_FRAME = 2, ST_DELAY = 3, ST_TRIG = 4, ST_RUN = 5;

    logic            clock;
    logic            reset;
    logic [1:0]      pllLocked, configChanged, frameStart, fullcycle;
    logic [1:0]      startTrig, videoReset, runningOut;
    logic [1:0][7:0] restartCount;
    logic [1:0][2:0] stateOut;

    int total = 0;
    int bad   = 0;

    video_start_controller #(.START_DELAY(16), .LOCK_STABLE(1024), .TIMEOUT(100)) dutA (
        .clock(clock), .reset(reset), .pll_locked(pllLocked[0]), .config_changed(configChanged[0]),
        .input_frame_start(frameStart[0]), .fullcycle(fullcycle[0]), .starttrigger(startTrig[0]),
        .video_reset(videoReset[0]), .running(runningOut[0]), .restart_count(restartCount[0]),
        .state(stateOut[0])
    );

    video_start_controller #(.START_DELAY(0), .LOCK_STABLE(4), .TIMEOUT(100)) dutB (
        .clock(clock), .reset(reset), .pll_locked(pllLocked[1]), .config_changed(configChanged[1]),
        .input_frame_start(frameStart[1]), .fullcycle(fullcycle[1]), .starttrigger(startTrig[1]),
        .video_reset(videoReset[1]), .running(runningOut[1]), .restart_count(restartCount[1]),
        .state(stateOut[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int sdOf(input int i);
        return (i == 0) ? 16 : 0;
    endfunction

    function automatic int lsOf(input int i);
        return (i == 0) ? 1024 : 4;
    endfunction

    // Model tracks when each phase began (absolute cycle numbers) rather than counters.
    int cyc = 0;
    int mState [2];
    int mEnter [2];
    int mLockStart [2];
    int mFrameCyc [2];
    int mKick [2];
    int mRestarts [2];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mState[i]     <= ST_HOLD;
                mEnter[i]     <= cyc;
                mLockStart[i] <= 0;
                mFrameCyc[i]  <= 0;
                mKick[i]      <= 0;
                mRestarts[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (mState[i])
                    ST_HOLD: begin
                        if (configChanged[i]) begin
                            mEnter[i] <= cyc + 1;
                        end else if (cyc - mEnter[i] == 15) begin
                            mState[i]     <= ST_LOCK;
                            mLockStart[i] <= cyc + 1;
                        end
                    end
                    ST_LOCK: begin
                        if (configChanged[i]) begin
                            mState[i] <= ST_HOLD;
                            mEnter[i] <= cyc + 1;
                        end else if (!pllLocked[i]) begin
                            mLockStart[i] <= cyc + 1;
                        end else if (cyc - mLockStart[i] + 1 == lsOf(i)) begin
                            mState[i] <= ST_FRAME;
                        end
                    end
                    default: begin
                        if (!pllLocked[i]) begin
                            mState[i]     <= ST_LOCK;
                            mLockStart[i] <= cyc + 1;
                        end else if (configChanged[i]) begin
                            mState[i] <= ST_HOLD;
                            mEnter[i] <= cyc + 1;
                        end else if (mState[i] == ST_FRAME) begin
                            if (frameStart[i]) begin
                                mFrameCyc[i] <= cyc;
                                mState[i]    <= (sdOf(i) == 0) ? ST_TRIG : ST_DELAY;
                            end
                        end else if (mState[i] == ST_DELAY) begin
                            if (cyc == mFrameCyc[i] + sdOf(i)) mState[i] <= ST_TRIG;
                        end else if (mState[i] == ST_TRIG) begin
                            mState[i] <= ST_RUN;
                            mKick[i]  <= cyc + 1;
                        end else if (frameStart[i]) begin
                            mKick[i] <= cyc + 1;
                        end else if (cyc - mKick[i] == 99) begin
                            mState[i]    <= ST_HOLD;
                            mEnter[i]    <= cyc + 1;
                            mRestarts[i] <= (mRestarts[i] < 255) ? mRestarts[i] + 1 : 255;
                        end
                    end
                endcase
            end
            cyc <= cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < 2; i++) begin
            string tag;
            tag = (i == 0) ? "A" : "B";
            checkOutput({tag, " state"}, int'(stateOut[i]), mState[i]);
            checkOutput({tag, " starttrigger"}, int'(startTrig[i]), (mState[i] == ST_TRIG) ? 1 : 0);
            checkOutput({tag, " video_reset"}, int'(videoReset[i]), (mState[i] <= ST_FRAME) ? 1 : 0);
            checkOutput({tag, " running"}, int'(runningOut[i]),
                        (mState[i] == ST_RUN && fullcycle[i]) ? 1 : 0);
            checkOutput({tag, " restart_count"}, int'(restartCount[i]), mRestarts[i]);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        compareAll();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic pll, input logic cfg,
                                 input logic frame, input logic full);
        pllLocked[i]     = pll;
        configChanged[i] = cfg;
        frameStart[i]    = frame;
        fullcycle[i]     = full;
    endtask

    task automatic waitState(input int i, input int st, input int budget, input string name);
        int k;
        k = 0;
        while (mState[i] != st && k < budget) begin
            tick();
            k++;
        end
        checkOutput(name, int'(stateOut[i]), st);
    endtask

    task automatic keepAlive(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            frameStart = (k % 40 == 39) ? 2'b11 : 2'b00;
            tick();
        end
        frameStart = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("reset state A", int'(stateOut[0]), ST_HOLD);
        checkOutput("reset video_reset A", int'(videoReset[0]), 1);
        checkOutput("reset starttrigger A", int'(startTrig[0]), 0);
        checkOutput("reset restart_count B", int'(restartCount[1]), 0);
        reset = 1'b0;

        // Power-up: 16 HOLD cycles, then lock qualification with a one-cycle glitch.
        repeat (15) tick();
        checkOutput("hold cycle 15 A", int'(stateOut[0]), ST_HOLD);
        tick();
        checkOutput("hold exit A", int'(stateOut[0]), ST_LOCK);
        repeat (500) tick();
        pllLocked[0] = 1'b0;
        tick();
        pllLocked[0] = 1'b1;
        repeat (1023) tick();
        checkOutput("lock restart still waiting A", int'(stateOut[0]), ST_LOCK);
        tick();
        checkOutput("lock done A", int'(stateOut[0]), ST_FRAME);
        checkOutput("lock done B", int'(stateOut[1]), ST_FRAME);
        repeat (459) tick();

        // Frame at cycle 2000 for both instances.
        checkOutput("video_reset before frame A", int'(videoReset[0]), 1);
        frameStart   = 2'b11;
        fullcycle[1] = 1'b1;
        tick();
        frameStart = 2'b00;
        checkOutput("delay entry A", int'(stateOut[0]), ST_DELAY);
        checkOutput("video_reset fall A", int'(videoReset[0]), 0);
        checkOutput("zero delay trigger B", int'(startTrig[1]), 1);
        tick();
        checkOutput("single trigger B", int'(startTrig[1]), 0);
        checkOutput("run B", int'(stateOut[1]), ST_RUN);
        fullcycle[1] = 1'b0;
        #1;
        checkOutput("running follows fullcycle low B", int'(runningOut[1]), 0);
        fullcycle[1] = 1'b1;
        #1;
        checkOutput("running follows fullcycle high B", int'(runningOut[1]), 1);
        repeat (14) tick();
        checkOutput("no early trigger A", int'(startTrig[0]), 0);
        tick();
        checkOutput("trigger at frame+17 A", int'(startTrig[0]), 1);
        tick();
        checkOutput("trigger one cycle A", int'(startTrig[0]), 0);
        checkOutput("run A", int'(stateOut[0]), ST_RUN);
        keepAlive(120);
        checkOutput("run kept alive A", int'(stateOut[0]), ST_RUN);

        // Config change in RUN, then a full restart sequence on the next frame.
        configChanged[0] = 1'b1;
        tick();
        configChanged[0] = 1'b0;
        checkOutput("config to hold A", int'(stateOut[0]), ST_HOLD);
        checkOutput("config video_reset A", int'(videoReset[0]), 1);
        checkOutput("config keeps count A", int'(restartCount[0]), 0);
        waitState(0, ST_FRAME, 1100, "relock A");
        frameStart[0] = 1'b1;
        tick();
        frameStart[0] = 1'b0;
        repeat (16) tick();
        checkOutput("retrigger A", int'(startTrig[0]), 1);
        tick();

        // Lost lock and config change together: lock wins.
        pllLocked[0]     = 1'b0;
        configChanged[0] = 1'b1;
        tick();
        pllLocked[0]     = 1'b1;
        configChanged[0] = 1'b0;
        checkOutput("lock priority A", int'(stateOut[0]), ST_LOCK);
        checkOutput("lock priority video_reset A", int'(videoReset[0]), 1);

        // Fresh reset, then starve B of frames to drive the watchdog to saturation.
        reset = 1'b1;
        repeat (2) tick();
        checkOutput("restart_count cleared by reset B", int'(restartCount[1]), 0);
        reset = 1'b0;
        waitState(1, ST_FRAME, 100, "B first frame wait");
        frameStart[1] = 1'b1;
        tick();
        frameStart[1] = 1'b0;
        checkOutput("B trigger", int'(stateOut[1]), ST_TRIG);
        tick();
        checkOutput("B run entry", int'(stateOut[1]), ST_RUN);
        repeat (99) tick();
        checkOutput("B run before timeout", int'(stateOut[1]), ST_RUN);
        tick();
        checkOutput("B timeout hold", int'(stateOut[1]), ST_HOLD);
        checkOutput("B restart_count 1", int'(restartCount[1]), 1);
        for (int it = 1; it < 300; it++) begin
            waitState(1, ST_FRAME, 100, "B frame wait");
            frameStart[1] = 1'b1;
            tick();
            frameStart[1] = 1'b0;
            waitState(1, ST_HOLD, 200, "B timeout");
        end
        checkOutput("B restart_count saturated", int'(restartCount[1]), 255);

        // Randomized traffic on both instances.
        for (int k = 0; k < 12000; k++) begin
            for (int i = 0; i < 2; i++) begin
                pllLocked[i]     = ($urandom_range(0, (i == 0) ? 3000 : 200) != 0);
                configChanged[i] = ($urandom_range(0, (i == 0) ? 4000 : 500) == 0);
                frameStart[i]    = ($urandom_range(0, 60) == 0);
                if ($urandom_range(0, 20) == 0) fullcycle[i] = ~fullcycle[i];
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_start_controller.md
VIDEO_START_CONTROLLER -- requirements
Module: video_start_controller

Interface
REQ-001 Parameter: START_DELAY, 16, cycles from accepted input_frame_start to the starttrigger pulse (0 allowed).
REQ-002 Parameter: LOCK_STABLE, 1024, consecutive pll_locked-high cycles required before the block waits for a frame.
REQ-003 Parameter: TIMEOUT, 4194304, cycles in RUN without input_frame_start before a forced restart.
REQ-004 Port: clock  in  1  pixel clock; the only clock of the block.
REQ-005 Port: reset  in  1  asynchronous, active-high; clock is the clock.
REQ-006 Port: pll_locked  in  1  output-PLL lock, already synchronized to clock.
REQ-007 Port: config_changed  in  1  single-cycle pulse on any video-config or line_doubler/is_interlaced change.
REQ-008 Port: input_frame_start  in  1  single-cycle pulse at the first captured pixel of a frame, already synchronized.
REQ-009 Port: fullcycle  in  1  from the output generator; high after 15 output vsync periods.
REQ-010 Port: starttrigger  out  1  single-cycle start pulse to the output generator.
REQ-011 Port: video_reset  out  1  reset to the output generator and its delay lines.
REQ-012 Port: running  out  1  output timing is stable.
REQ-013 Port: restart_count  out  8  number of watchdog restarts, saturating.
REQ-014 Port: state  out  3  current state encoding, for debug.

Function
REQ-015 States and encodings: HOLD=0, WAIT_LOCK=1, WAIT_FRAME=2, DELAY=3, TRIGGER=4, RUN=5; codes 6–7 unused and SHALL go to HOLD.
REQ-016 HOLD: a 4-bit counter counts 16 cycles; on the 16th cycle, go to WAIT_LOCK.
REQ-017 WAIT_LOCK: a counter increments while pll_locked=1 and clears when pll_locked=0; at count LOCK_STABLE-1 with pll_locked=1, go to WAIT_FRAME.
REQ-018 WAIT_FRAME: on input_frame_start=1, go to DELAY and load the delay counter; if START_DELAY=0, go directly to TRIGGER.
REQ-019 DELAY: count START_DELAY cycles, counting the entry cycle as cycle 1, then go to TRIGGER; starttrigger is high exactly START_DELAY+1 cycles after the accepted input_frame_start cycle.
REQ-020 TRIGGER: lasts one cycle with starttrigger=1, then goes to RUN unconditionally.
REQ-021 RUN: a 24-bit watchdog clears on every input_frame_start and otherwise increments.
REQ-022 Watchdog restart: when the watchdog reaches TIMEOUT-1 without input_frame_start, go to HOLD and increment restart_count, saturating at 255.
REQ-023 input_frame_start in DELAY, TRIGGER or RUN SHALL NOT restart the delay sequence.
REQ-024 video_reset=1 in HOLD, WAIT_LOCK and WAIT_FRAME; video_reset=0 in DELAY, TRIGGER and RUN; registered, so it changes in the cycle the state changes.
REQ-025 starttrigger=1 only in TRIGGER and SHALL never be high for two consecutive cycles.
REQ-026 running=1 only when state=RUN and fullcycle=1.
REQ-027 Priority 1: pll_locked=0 in any state other than HOLD or WAIT_LOCK SHALL go to WAIT_LOCK with the lock counter cleared; restart_count is unchanged.
REQ-028 Priority 2: config_changed=1 in any state other than HOLD SHALL go to HOLD with the HOLD counter cleared; config_changed in HOLD restarts the 16-cycle count.
REQ-029 Watchdog and frame events rank below REQ-027 and REQ-028 when they occur in the same cycle.
REQ-030 All outputs SHALL be registered; the only combinational path from an input to an output is fullcycle to running, through REQ-026.

Reset
REQ-031 While reset=1: state=HOLD, starttrigger=0, video_reset=1, running=0, restart_count=0, and all counters are 0.
REQ-032 After reset deasserts, the first transition is HOLD→WAIT_LOCK after 16 clocks.
REQ-033 restart_count clears only on reset.

Verification
REQ-034 Bench: pll_locked=1 from time 0, reset released, input_frame_start at cycle 2000 → starttrigger high at cycle 2017 only, video_reset falls at cycle 2001, state=5 afterwards.
REQ-035 Bench: pll_locked drops for 1 cycle at count 500 in WAIT_LOCK → the lock count restarts, and WAIT_FRAME is entered 1024 cycles after pll_locked returns.
REQ-036 Bench: config_changed pulse in RUN → state=0 and video_reset=1 on the next cycle, starttrigger=0, and a full restart sequence follows on the next frame.
REQ-037 Bench: TIMEOUT=100, no frame pulses in RUN → HOLD entered after 100 cycles, restart_count=1; repeat 300 times → restart_count=255.
REQ-038 Bench: config_changed and pll_locked=0 in the same RUN cycle → state=1 (pll_locked has priority).
REQ-039 Bench: START_DELAY=0 → starttrigger exactly 1 cycle after input_frame_start; fullcycle=1 in RUN → running=1 in the same cycle.
